// File: rtl/dut_slave_regfile.sv
// dut_slave_regfile: slave-side responder for the cmd/adr/data bus.
// Decodes 4-bit commands against a 16 x 4-bit register file:
//   0 NOP, 1 WRITE, 2 READ (registered result, latency 1), 3 INC (4-bit wrap),
//   4 CLEAR (16-cycle sweep to RESET_VAL, busy high meanwhile), 5..15 illegal.
// Illegal commands, and any non-NOP command arriving during a sweep, pulse err
// and bump the saturating err_cnt.
// Optional build macro DUT_SLAVE_CMD_STATS_EN adds the cmd_seen sticky bitmap
// and the hit_cnt count of accepted commands.
module dut_slave_regfile #(
  parameter int          CNT_W     = 8,
  parameter logic [3:0]  RESET_VAL = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cmd,
  input  logic [3:0]       adr,
  input  logic [3:0]       data,
  output logic [3:0]       rdata,
  output logic             rvalid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
`ifdef DUT_SLAVE_CMD_STATS_EN
  ,
  output logic [15:0]      cmd_seen,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_WRITE = 4'd1,
    CMD_READ  = 4'd2,
    CMD_INC   = 4'd3,
    CMD_CLEAR = 4'd4
  } cmd_e;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] ptr_q;
  logic [3:0] mem [16];

  logic do_write;
  logic do_read;
  logic do_inc;
  logic do_clear;
  logic flag_err;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from values held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: CLEAR starts a sweep, clearing entry 15 ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_clear) state_d = SWEEP;
      SWEEP:   if (ptr_q == 4'hF) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/decode logic: what the sampled command does this cycle.
  // NOTE: every signal gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    do_inc   = 1'b0;
    do_clear = 1'b0;
    flag_err = 1'b0;
    busy     = (state_q == SWEEP);
    if (state_q == IDLE) begin
      // An X on cmd matches no item and falls into the illegal branch.
      case (cmd)
        CMD_NOP:   ;
        CMD_WRITE: do_write = 1'b1;
        CMD_READ:  do_read  = 1'b1;
        CMD_INC:   do_inc   = 1'b1;
        CMD_CLEAR: do_clear = 1'b1;
        default:   flag_err = 1'b1;
      endcase
    end else begin
      // Everything but NOP is dropped while the sweep runs, CLEAR included.
      case (cmd)
        CMD_NOP: ;
        default: flag_err = 1'b1;
      endcase
    end
  end

  // Sweep pointer: walks 0..15 during SWEEP and wraps back to 0 at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr_q <= 4'd0;
    else if (state_q == SWEEP)  ptr_q <= ptr_q + 4'd1;
    else if (do_clear)          ptr_q <= 4'd0;
  end

  // Register file: sweep clear, write, or increment.
  // NOTE: the array is built from flops and every entry is reset here, since
  // reset (including one that aborts a sweep) must leave all 16 at RESET_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= RESET_VAL;
    end else if (state_q == SWEEP) begin
      mem[ptr_q] <= RESET_VAL;
    end else if (do_write) begin
      mem[adr] <= data;
    end else if (do_inc) begin
      mem[adr] <= mem[adr] + 4'd1;
    end
  end

  // Read port: captures the entry as held before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= 4'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= do_read;
      if (do_read) rdata <= mem[adr];
    end
  end

  // Error pulse and saturating error counter, updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= flag_err;
      if (flag_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef DUT_SLAVE_CMD_STATS_EN
  // Command statistics: sticky bitmap of every code seen and a saturating
  // count of commands that actually took effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_seen <= '0;
      hit_cnt  <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (cmd == 4'(k)) cmd_seen[k] <= 1'b1;
      end
      if ((do_write || do_read || do_inc || do_clear) && (hit_cnt != CNT_MAX))
        hit_cnt <= hit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dut_slave_regfile.sv
// Directed testbench for dut_slave_regfile (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_dut_slave_regfile;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       cmd = 4'd0;
  logic [3:0]       adr = 4'd0;
  logic [3:0]       data = 4'd0;
  logic [3:0]       rdata;
  logic             rvalid;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
`ifdef DUT_SLAVE_CMD_STATS_EN
  logic [15:0]      cmd_seen;
  logic [CNT_W-1:0] hit_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int exp_err_cnt = 0;

  dut_slave_regfile #(.CNT_W(CNT_W), .RESET_VAL(4'h0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .adr     (adr),
    .data    (data),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .err     (err),
    .err_cnt (err_cnt)
`ifdef DUT_SLAVE_CMD_STATS_EN
    ,
    .cmd_seen(cmd_seen),
    .hit_cnt (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present one command for one cycle, then sit just after the edge.
  task automatic step(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
    cmd = c; adr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [3:0] rd, output logic rv);
    step(4'd2, a, 4'd0);
    rd = rdata;
    rv = rvalid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata, rvalid, busy, err, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdata=%0h rvalid=%0b busy=%0b err=%0b err_cnt=%0d exp all 0",
               rdata, rvalid, busy, err, err_cnt);
    end
    rst_n = 1'b1;
    exp_err_cnt = 0;
  endtask

  task automatic test_read_after_reset;
    logic [3:0] rd;
    logic       rv;
    do_read(4'd5, rd, rv);
    checks++;
    if ({rv, rd} !== {1'b1, 4'h0}) begin
      failures++;
      $display("FAIL read_reset_val got rvalid=%0b rdata=%0h exp rvalid=1 rdata=0", rv, rd);
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL read_reset_errcnt got %0d exp 0", err_cnt);
    end
    step(4'd0, 4'd0, 4'd0);
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_one_cycle got %0b exp 0", rvalid);
    end
  endtask

  task automatic test_write_read;
    logic [3:0] rd;
    logic       rv;
    step(4'd1, 4'd3, 4'd9);
    checks++;
    if ({rvalid, err} !== 2'b00) begin
      failures++;
      $display("FAIL write_no_pulse got rvalid=%0b err=%0b exp 0 0", rvalid, err);
    end
    do_read(4'd3, rd, rv);
    checks++;
    if ({rv, rd, err} !== {1'b1, 4'h9, 1'b0}) begin
      failures++;
      $display("FAIL raw_adr3 got rvalid=%0b rdata=%0h err=%0b exp 1 9 0", rv, rd, err);
    end
  endtask

  task automatic test_inc_wrap;
    logic [3:0] rd;
    logic       rv;
    step(4'd1, 4'd7, 4'd15);
    step(4'd3, 4'd7, 4'd0);
    do_read(4'd7, rd, rv);
    checks++;
    if ({rv, rd} !== {1'b1, 4'h0}) begin
      failures++;
      $display("FAIL inc_wrap got rvalid=%0b rdata=%0h exp 1 0", rv, rd);
    end
    step(4'd3, 4'd7, 4'd0);
    step(4'd3, 4'd7, 4'd0);
    do_read(4'd7, rd, rv);
    checks++;
    if ({rv, rd} !== {1'b1, 4'h2}) begin
      failures++;
      $display("FAIL inc_twice got rvalid=%0b rdata=%0h exp 1 2", rv, rd);
    end
  endtask

  task automatic test_illegal;
    step(4'd9, 4'd0, 4'd0);
    exp_err_cnt++;
    checks++;
    if ({err, rvalid, err_cnt} !== {1'b1, 1'b0, 8'(exp_err_cnt)}) begin
      failures++;
      $display("FAIL illegal_pulse got err=%0b rvalid=%0b err_cnt=%0d exp 1 0 %0d",
               err, rvalid, err_cnt, exp_err_cnt);
    end
    step(4'd0, 4'd0, 4'd0);
    checks++;
    if ({err, err_cnt} !== {1'b0, 8'(exp_err_cnt)}) begin
      failures++;
      $display("FAIL illegal_one_cycle got err=%0b err_cnt=%0d exp 0 %0d", err, err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_clear_sweep;
    int busy_cycles = 0;
    int err_pulses = 0;
    int rv_pulses = 0;
    int bad = 0;
    bit done = 0;
    logic [3:0] rd;
    logic       rv;
    for (int i = 0; i < 16; i++) step(4'd1, 4'(i), 4'd10);
    do_read(4'd12, rd, rv);
    checks++;
    if ({rv, rd} !== {1'b1, 4'hA}) begin
      failures++;
      $display("FAIL fill_value got rvalid=%0b rdata=%0h exp 1 a", rv, rd);
    end
    step(4'd4, 4'd0, 4'd0);
    if (busy) busy_cycles++;
    // Reads every sweep cycle, plus a CLEAR (must not restart) and a WRITE to
    // an already-swept entry (must not land).
    for (int it = 1; it <= 40 && !done; it++) begin
      if (it == 8)       step(4'd4, 4'd0, 4'd0);
      else if (it == 16) step(4'd1, 4'd0, 4'd5);
      else               step(4'd2, 4'd0, 4'd0);
      if (err) err_pulses++;
      if (rvalid) rv_pulses++;
      if (busy) busy_cycles++;
      else done = 1;
    end
    step(4'd0, 4'd0, 4'd0);
    exp_err_cnt += 16;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL sweep_timeout busy still %0b after 40 cycles exp 0", busy);
    end
    checks++;
    if (busy_cycles != 16) begin
      failures++;
      $display("FAIL sweep_busy_len got %0d exp 16", busy_cycles);
    end
    checks++;
    if (err_pulses != 16 || rv_pulses != 0) begin
      failures++;
      $display("FAIL sweep_drops got err=%0d rvalid=%0d exp 16 0", err_pulses, rv_pulses);
    end
    checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      failures++;
      $display("FAIL sweep_errcnt got %0d exp %0d", err_cnt, exp_err_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), rd, rv);
      if ({rv, rd, err} !== {1'b1, 4'h0, 1'b0}) begin
        bad++;
        $display("  entry %0d rvalid=%0b rdata=%0h err=%0b", i, rv, rd, err);
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sweep_readback got %0d bad entries exp 0", bad);
    end
  endtask

  task automatic test_err_saturate;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(4'd9, 4'd0, 4'd0);
      if (exp_err_cnt < 255) exp_err_cnt++;
      if ({err, rvalid, err_cnt} !== {1'b1, 1'b0, 8'(exp_err_cnt)}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL err_stream got %0d bad cycles exp 0", bad);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate got %0d exp 255", err_cnt);
    end
    step(4'd0, 4'd0, 4'd0);
    checks++;
    if ({err, err_cnt} !== {1'b0, 8'd255}) begin
      failures++;
      $display("FAIL err_hold got err=%0b err_cnt=%0d exp 0 255", err, err_cnt);
    end
  endtask

  task automatic test_reset_during_sweep;
    int bad = 0;
    logic [3:0] rd;
    logic       rv;
    for (int i = 0; i < 16; i++) step(4'd1, 4'(i), 4'(i) | 4'h8);
    step(4'd4, 4'd0, 4'd0);
    repeat (5) step(4'd0, 4'd0, 4'd0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL sweep6_busy got %0b exp 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, err_cnt, rvalid} !== '0) begin
      failures++;
      $display("FAIL abort_async got busy=%0b err_cnt=%0d rvalid=%0b exp 0 0 0", busy, err_cnt, rvalid);
    end
    #2;
    rst_n = 1'b1;
    exp_err_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), rd, rv);
      if ({rv, rd} !== {1'b1, 4'h0}) begin
        bad++;
        $display("  entry %0d rvalid=%0b rdata=%0h", i, rv, rd);
      end
    end
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_readback got %0d bad entries busy=%0b exp 0 0", bad, busy);
    end
  endtask

`ifdef DUT_SLAVE_CMD_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(4'd1, 4'd2, 4'd3);
    step(4'd2, 4'd2, 4'd0);
    step(4'd9, 4'd0, 4'd0);
    checks++;
    if ({cmd_seen, hit_cnt} !== {16'h0206, 8'd2}) begin
      failures++;
      $display("FAIL stats got cmd_seen=%04h hit_cnt=%0d exp 0206 2", cmd_seen, hit_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_inc_wrap();
    test_illegal();
    test_clear_sweep();
    test_err_saturate();
    test_reset_during_sweep();
`ifdef DUT_SLAVE_CMD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dut_slave_regfile.md
Name: dut_slave_regfile

Overview:
- Slave-side responder for the cmd/adr/data bus driven by the testbench master.
- Decodes 4-bit commands against a 16-entry x 4-bit register file and returns read data with fixed latency.
- Flags illegal or dropped commands.
- Sits behind the slave modport as the DUT that the covergroups in the bench observe.

Parameters:
- CNT_W, 8: width of the saturating error counter.
- RESET_VAL, 4'h0: value loaded into every register-file entry on reset and by CLEAR.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd  input  4  command code, sampled every posedge.
- adr  input  4  register-file entry index 0..15.
- data  input  4  write operand.
- rdata  output  4  read result.
- rvalid  output  1  one-cycle pulse qualifying rdata.
- busy  output  1  high while a CLEAR sweep is in progress.
- err  output  1  one-cycle pulse for an illegal or dropped command.
- err_cnt  output  CNT_W  saturating count of err pulses.

Behaviour:
- Reset: asynchronous assert, synchronous deassert timing is not required. All 16 entries = RESET_VAL, rdata=0, rvalid=0, busy=0, err=0, err_cnt=0, state=IDLE, sweep pointer=0.
- Command codes:
  - 0 NOP.
  - 1 WRITE: mem[adr] <= data.
  - 2 READ.
  - 3 INC: mem[adr] <= mem[adr]+1, 4-bit wrap, 15->0.
  - 4 CLEAR: sweep all entries to RESET_VAL.
  - 5..15 illegal.
- FSM states are IDLE and SWEEP.
- IDLE:
  - Commands act at the posedge where they are sampled.
  - WRITE/INC update the entry at that edge.
  - READ: rdata = mem[adr] as held before that edge's updates, registered; rvalid=1 for exactly the following cycle (latency 1).
  - Read-after-write to the same adr on consecutive cycles returns the written value.
  - CLEAR: next state SWEEP, pointer=0, busy=1 from the next cycle.
  - Illegal code: err=1 for one cycle; no state change.
- SWEEP:
  - Each cycle mem[ptr] <= RESET_VAL, ptr++.
  - When ptr==15 is cleared, return to IDLE; busy=0 the cycle after.
  - busy is high for exactly 16 cycles.
  - Any non-NOP command sampled while busy is dropped (no memory effect, no rvalid) and pulses err.
  - A CLEAR issued during SWEEP is also dropped and does not restart the sweep.
- rvalid and err are never both caused by the same command. rvalid is low on every cycle not following a legal READ.
- err_cnt increments on each err pulse and saturates at 2^CNT_W-1 with no wrap.
- X on cmd is treated as illegal (err pulse). adr/data are don't-care for NOP and CLEAR.
- Reset during SWEEP aborts immediately: busy=0 and all entries = RESET_VAL.

Optional Feature:
- Macro: DUT_SLAVE_CMD_STATS_EN.
- When defined, adds two outputs:
  - cmd_seen[15:0]: sticky bitmap; bit k is set the first cycle cmd==k is sampled, including illegal and dropped commands. Cleared only by rst_n.
  - hit_cnt[CNT_W-1:0]: saturating count of accepted (non-dropped, legal, non-NOP) commands.
- When undefined, neither port nor the logic behind it exists, and the port list is exactly as above.

Test Plan:
- Reset then READ adr 5 -> next cycle rvalid=1, rdata=RESET_VAL (0); err_cnt=0.
- WRITE adr 3 data 9, then READ adr 3 on the next cycle -> rvalid next cycle with rdata=9.
- WRITE adr 7 data 15, INC adr 7, READ adr 7 -> rdata=0 (wrap); INC twice more then READ -> rdata=2.
- WRITE all 16 entries to 10, CLEAR, then drive READ adr 0 on every cycle of the sweep:
  - busy high exactly 16 cycles;
  - 16 err pulses, err_cnt=16, no rvalid;
  - READ after busy falls returns 0 for every entry.
- Drive cmd=9 for 300 cycles with CNT_W=8 -> err pulses every cycle; err_cnt stops at 255.
- Assert rst_n low during sweep cycle 6 after writing non-zero values -> busy=0 immediately; all entries read back RESET_VAL after release.
- With DUT_SLAVE_CMD_STATS_EN: issue cmds 1,2,9 -> cmd_seen=16'h0206, hit_cnt=2.
